ysyx_22050019_if_id_buf: RTL
============================

# ysyx_22050019_if_id_buf

Two-entry elastic buffer between the instruction fetch stage and the decode stage of the ysyx_22050019 five-stage pipeline. It captures each fetched instruction and its PC, presents them to decode with a valid/ready handshake, and returns a registered stall to fetch. That stall gates the fetch-side AXI R-channel acceptance, so it must never depend combinationally on decode's ready. A pipeline flush from a taken jump or branch discards all buffered entries.

## Interface
- RESET_NOP, 32'h00000013, instruction word driven on inst_o while no valid entry is presented (used only with the config macro).
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ifu_ok_i  input  1  fetch has an instruction this cycle: R beat valid and rready high.
- inst_addr_i  input  64  PC of the offered instruction.
- inst_i  input  32  offered instruction word, already lane-selected.
- pc_stall_o  output  1  to fetch; when high, fetch must not commit or advance its PC.
- flush_i  input  1  jump/branch redirect; kills buffer contents and same-cycle push.
- id_valid_o  output  1  head entry valid toward decode.
- id_ready_i  input  1  decode accepts head this cycle.
- inst_addr_o  output  64  head entry PC.
- inst_o  output  32  head entry instruction.
- occupancy_o  output  2  entries held (0..2), for debug/perf.

## Operation
- Storage: two entries {addr[63:0], inst[31:0]}.
  - Circular with 1-bit rd_ptr/wr_ptr plus a 2-bit count, or an equivalent head/skid register pair.
- Push = ifu_ok_i && !pc_stall_o && !flush_i. Pop = id_valid_o && id_ready_i && !flush_i.
- pc_stall_o = (count == 2). It is derived only from flops, never from id_ready_i, flush_i or ifu_ok_i.
- id_valid_o = (count != 0). inst_addr_o and inst_o show the entry at rd_ptr.
- Count updates:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop together: count unchanged. The new entry is written at wr_ptr and both pointers advance.
- Flush: count, rd_ptr and wr_ptr go to 0 next edge. Any same-cycle push and pop are ignored. Entry data is not cleared.
- An offer while pc_stall_o is high is not consumed. Fetch holds the instruction because its commit is gated by the stall.
- Pointer wrap: each 1-bit pointer toggles on its own advance. No overflow is possible because push is blocked at count 2. No underflow is possible because pop requires count != 0.

## Timing
- Reset (async assert), all go to 0: count, pointers, id_valid_o, pc_stall_o, occupancy_o.
  - Storage also resets to 0.
  - inst_addr_o resets to 0.
  - inst_o resets per Configuration.
- Latency: an instruction pushed at edge N is visible with id_valid_o=1 after edge N. That is 1 cycle from ifu_ok_i to decode.
- Throughput: 1 instruction/cycle sustained while id_ready_i=1. Count stays at 0↔1.
- Backpressure: count reaches 2 one edge after the second un-popped push. pc_stall_o rises in that same cycle and falls the cycle after the first pop.
- Flush while count=2: pc_stall_o=0 and id_valid_o=0 on the next cycle.
- Reset deassertion mid-operation takes effect synchronously from the next edge. Behaviour then matches the post-reset state.

## Configuration
- IFID_BUBBLE_NOP_EN defined:
  - While id_valid_o=0, inst_o = RESET_NOP and inst_addr_o = 0. This holds from reset onward.
  - Decode may therefore treat an invalid slot as a harmless addi x0,x0,0.
- Not defined:
  - inst_o and inst_addr_o always show the rd_ptr entry, even when invalid. After reset that is 0.
  - Decode must qualify these outputs with id_valid_o.

## Test plan
- Reset, then no stimulus → id_valid_o=0, pc_stall_o=0, occupancy_o=0. inst_o=0x00000013 with the macro, 0x00000000 without.
- Stream addr 0x80000000, 0x80000004, 0x80000008 with id_ready_i=1 → each appears on inst_addr_o one cycle later in order; occupancy_o ≤1; pc_stall_o never 1.
- id_ready_i=0, push 0x80000000 and 0x80000004 → occupancy_o=2 and pc_stall_o=1. A third offer (0x80000008) is not accepted. Raising id_ready_i pops 0x80000000, and pc_stall_o drops the next cycle.
- Count=1 (head 0x80000010) with simultaneous push 0x80000014 and pop → occupancy_o stays 1; next head is 0x80000014.
- Count=2 plus flush_i=1 with ifu_ok_i=1 (addr 0x80000100) in the same cycle → next cycle occupancy_o=0 and id_valid_o=0; addr 0x80000100 is never presented.
- Assert rst_n=0 asynchronously mid-stream with count=2 → outputs return to reset values before the next clock edge.

Source files
------------

// File: rtl/ysyx_22050019_if_id_buf.sv
// rtl/ysyx_22050019_if_id_buf.sv - two-entry IF/ID elastic buffer with registered fetch stall
//
// Captures each fetched {pc, instruction} pair and presents it to decode under a
// valid/ready handshake. The stall back to fetch comes straight from the entry
// count flops, so fetch-side R-channel acceptance never sees decode's ready
// combinationally.
//
// Optional feature macro: IFID_BUBBLE_NOP_EN
//   defined     - while no entry is valid, inst_o = RESET_NOP and inst_addr_o = 0
//   not defined - inst_o / inst_addr_o always show the rd_ptr entry
//
// Ports:
//   clk, rst_n              core clock, asynchronous active-low reset
//   ifu_ok_i                fetch offers an instruction this cycle
//   inst_addr_i, inst_i     offered PC and instruction word
//   pc_stall_o              buffer full; fetch must hold its PC and offer
//   flush_i                 redirect; drops buffer contents and same-cycle push/pop
//   id_valid_o, id_ready_i  handshake toward decode
//   inst_addr_o, inst_o     head entry
//   occupancy_o             entries held (0..2)

module ysyx_22050019_if_id_buf #(
  parameter logic [31:0] RESET_NOP = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifu_ok_i,
  input  logic [63:0] inst_addr_i,
  input  logic [31:0] inst_i,
  output logic        pc_stall_o,
  input  logic        flush_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [63:0] inst_addr_o,
  output logic [31:0] inst_o,
  output logic [1:0]  occupancy_o
);

  logic [63:0] addr_q [2];
  logic [31:0] inst_q [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic        push;
  logic        pop;

  assign pc_stall_o  = (count == 2'd2);
  assign id_valid_o  = (count != 2'd0);
  assign occupancy_o = count;

  // Push is blocked by the registered stall, so count can never exceed 2;
  // pop requires a valid head, so count can never go below 0.
  assign push = ifu_ok_i && !pc_stall_o && !flush_i;
  assign pop  = id_valid_o && id_ready_i && !flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= 2'd0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      addr_q[0] <= 64'd0;
      addr_q[1] <= 64'd0;
      inst_q[0] <= 32'd0;
      inst_q[1] <= 32'd0;
    end else if (flush_i) begin
      // Entry data is left in place; only the bookkeeping is cleared.
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        addr_q[wr_ptr] <= inst_addr_i;
        inst_q[wr_ptr] <= inst_i;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef IFID_BUBBLE_NOP_EN
  // An empty slot looks like addi x0,x0,0 at pc 0, so decode can ignore valid.
  assign inst_o      = id_valid_o ? inst_q[rd_ptr] : RESET_NOP;
  assign inst_addr_o = id_valid_o ? addr_q[rd_ptr] : 64'd0;
`else
  assign inst_o      = inst_q[rd_ptr];
  assign inst_addr_o = addr_q[rd_ptr];
`endif

endmodule
